// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: controller state encoding and
// the in-place radix-2 DIT butterfly address and twiddle formulas.
`default_nettype none

package fft_pkg;

  localparam int N_LOG2_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FIRE  = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } fft_state_t;

  // Butterfly k of a stage pairs samples half = 2**stage apart, grouped in blocks of 2*half.
  function automatic int bf_addr_a(input int stage, input int k);
    int half;
    half = 1 << stage;
    return ((k >> stage) << (stage + 1)) + (k & (half - 1));
  endfunction

  function automatic int bf_addr_b(input int stage, input int k);
    return bf_addr_a(stage, k) + (1 << stage);
  endfunction

  function automatic int bf_tw_idx(input int n_log2, input int stage, input int k);
    return (k & ((1 << stage) - 1)) << (n_log2 - 1 - stage);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// Combinational operand address and twiddle index generator for one butterfly.
`default_nettype none

module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT,
  parameter int SW     = $clog2(N_LOG2)
) (
  input  logic [SW-1:0]     stage,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_idx
);

  always_comb begin
    int s_i;
    int k_i;
    s_i    = int'(stage);
    k_i    = int'(k);
    addr_a = N_LOG2'(bf_addr_a(s_i, k_i));
    addr_b = N_LOG2'(bf_addr_b(s_i, k_i));
    tw_idx = (N_LOG2 - 1)'(bf_tw_idx(N_LOG2, s_i, k_i));
  end

endmodule

`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: walks every butterfly of
// every stage through READ/FIRE/WAIT/WRITE with a WAIT timeout abort.
`default_nettype none

module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2  = N_LOG2_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       start,
  input  logic                       bf_done,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       rd_en,
  output logic                       bf_start,
  output logic                       wr_en,
  output logic [N_LOG2-1:0]          addr_a,
  output logic [N_LOG2-1:0]          addr_b,
  output logic [N_LOG2-2:0]          tw_idx,
  output logic [$clog2(N_LOG2)-1:0]  stage
);

  localparam int                SW     = $clog2(N_LOG2);
  localparam int                TCW    = $clog2(TIMEOUT + 1);
  localparam logic [N_LOG2-2:0] K_LAST = {(N_LOG2 - 1){1'b1}};
  localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
  localparam logic [TCW-1:0]    T_LAST = TCW'(TIMEOUT - 1);

  fft_state_t          state, state_d;
  logic [N_LOG2-2:0]   k_q;
  logic [SW-1:0]       stage_q;
  logic [TCW-1:0]      tcnt;
  logic                err_q;

  logic                clr_cnt, adv, set_err, clr_err;
  logic                active, last_bf;
  logic [N_LOG2-1:0]   ag_a, ag_b;
  logic [N_LOG2-2:0]   ag_tw;

  assign last_bf = (k_q == K_LAST) && (stage_q == S_LAST);

  always_comb begin
    state_d = state;
    clr_cnt = 1'b0;
    adv     = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = READ;
          clr_cnt = 1'b1;
          clr_err = 1'b1;
        end
      end
      READ:  state_d = FIRE;
      FIRE:  state_d = WAIT;
      WAIT: begin
        // A result arriving on the expiry cycle still wins over the abort.
        if (bf_done) begin
          state_d = WRITE;
        end else if (tcnt == T_LAST) begin
          state_d = DONE;
          set_err = 1'b1;
          clr_cnt = 1'b1;
        end
      end
      WRITE: begin
        if (last_bf) begin
          state_d = DONE;
          clr_cnt = 1'b1;
        end else begin
          state_d = READ;
          adv     = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      tcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      if (clr_cnt) begin
        k_q     <= '0;
        stage_q <= '0;
      end else if (adv) begin
        if (k_q == K_LAST) begin
          k_q     <= '0;
          stage_q <= stage_q + 1'b1;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
      tcnt <= ((state == WAIT) && (state_d == WAIT)) ? tcnt + 1'b1 : '0;
      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  fft_addr_gen #(
    .N_LOG2 (N_LOG2),
    .SW     (SW)
  ) u_addr_gen (
    .stage  (stage_q),
    .k      (k_q),
    .addr_a (ag_a),
    .addr_b (ag_b),
    .tw_idx (ag_tw)
  );

  assign active   = (state == READ) || (state == FIRE) || (state == WAIT) || (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign rd_en    = (state == READ);
  assign bf_start = (state == FIRE);
  assign wr_en    = (state == WRITE);
  assign err      = err_q;
  // Address bus is held at zero whenever no butterfly is in flight.
  assign addr_a   = active ? ag_a    : '0;
  assign addr_b   = active ? ag_b    : '0;
  assign tw_idx   = active ? ag_tw   : '0;
  assign stage    = active ? stage_q : '0;

endmodule

`default_nettype wire

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter N_LOG2, default 3, meaning log2 of FFT length N (N = 2**N_LOG2, N_LOG2 >= 2).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max cycles spent in WAIT before abort.
REQ-003 Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 nReset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to run one complete N-point transform; sampled only in IDLE.
REQ-006 bf_done  in  1  butterfly datapath result ready; sampled only in WAIT.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse at end of transform.
REQ-009 err  out  1  sticky timeout flag; valid with done, cleared on next accepted start.
REQ-010 rd_en  out  1  one-cycle read strobe for operands at addr_a/addr_b.
REQ-011 bf_start  out  1  one-cycle launch strobe to butterfly datapath.
REQ-012 wr_en  out  1  one-cycle write-back strobe for results at addr_a/addr_b.
REQ-013 addr_a, addr_b  out  N_LOG2  operand/result sample addresses.
REQ-014 tw_idx  out  N_LOG2-1  twiddle ROM index.
REQ-015 stage  out  ceil(log2(N_LOG2))  current stage number, 0..N_LOG2-1.

Function
REQ-016 SHALL implement radix-2 DIT, in place; sample memory holds bit-reversed input before start.
REQ-017 SHALL use FSM states IDLE, READ, FIRE, WAIT, WRITE, DONE.
REQ-018 Transitions: IDLE->READ on start; READ->FIRE; FIRE->WAIT; WAIT->WRITE on bf_done; WRITE->READ unless last butterfly of last stage, else ->DONE; DONE->IDLE.
REQ-019 WAIT->DONE with err=1 when bf_done is still low after TIMEOUT cycles in WAIT; no wr_en is issued for that butterfly.
REQ-020 Strobes: rd_en only in READ; bf_start only in FIRE; wr_en only in WRITE; done only in DONE; all Moore outputs.
REQ-021 Counters: butterfly index k 0..N/2-1, incremented in WRITE; wrap to 0 increments stage; both zeroed on IDLE->READ.
REQ-022 With half = 2**stage and pos = k mod half, addressing SHALL be: addr_a = (k div half)*2*half + pos; addr_b = addr_a + half; tw_idx = pos * 2**(N_LOG2-1-stage).
REQ-023 addr_a, addr_b, tw_idx and stage SHALL stay stable from READ through WRITE of each butterfly.
REQ-024 start while busy SHALL be ignored; bf_done outside WAIT SHALL be ignored.
REQ-025 bf_done held high continuously SHALL advance exactly one butterfly per READ..WRITE pass (4 cycles minimum per butterfly).
REQ-026 A simultaneous timeout expiry and bf_done in the same cycle SHALL take the bf_done path (WRITE).

Reset
REQ-027 nReset low SHALL force IDLE, k=0, stage=0, timeout counter=0, err=0, all strobes 0, addresses 0, at any time including mid-transform.
REQ-028 After reset release, no strobe SHALL assert until start is sampled high in IDLE.

Structure
REQ-029 State enum, default N_LOG2 and the address/twiddle formulas SHALL live in package fft_pkg.
REQ-030 Address generation SHALL be a combinational sub-module fft_addr_gen (inputs: stage, k; outputs: addr_a, addr_b, tw_idx).

Verification
REQ-031 N_LOG2=3, start pulse, bf_done tied high -> 12 butterflies, done pulse 48 cycles after leaving IDLE, err=0.
REQ-032 Same run -> (addr_a,addr_b,tw_idx) sequence: stage0 (0,1,0)(2,3,0)(4,5,0)(6,7,0); stage1 (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage2 (0,4,0)(1,5,1)(2,6,2)(3,7,3).
REQ-033 bf_done asserted 5 cycles after each bf_start -> addresses stable throughout WAIT, exactly one wr_en per butterfly, 12 wr_en total.
REQ-034 TIMEOUT=8, bf_done never asserted -> done with err=1 at 8 cycles into first WAIT, zero wr_en; next start clears err.
REQ-035 nReset pulsed low during stage1 WAIT -> all outputs 0 and IDLE immediately; fresh start restarts at stage0 (0,1,0).
REQ-036 start pulsed during busy and bf_done pulsed during READ -> no restart, no extra advance; sequence identical to REQ-032.
